// File: rtl/ecc_scrub_ctrl.sv
// ecc_scrub_ctrl: background scrubber for a SEC-DED (72,64) protected array.
// It walks every word, reads it through the shared SEC-DED decoder and writes
// single-bit-corrected words back through the encoder. It counts SEC and DED events.
// Ports:
//   clk_i, rst_ni            clock and async active-low reset
//   en_i, clr_cnt_i          scrub enable, synchronous counter clear
//   mem_req_o/we/addr/wdata  array request to the arbiter, held until mem_gnt_i
//   mem_rvalid_i/rdata_i     read return
//   dec_in_o -> dec_*_i      registered read word into the shared decoder
//   enc_in_o -> enc_out_i    registered corrected data into the encoder
//   err_valid_o/uncorr/addr  per-error pulse with DED flag; address is sticky
//   corr_cnt_o/uncorr_cnt_o  saturating SEC and DED counters
module ecc_scrub_ctrl #(
    parameter int ADDR_W   = 10,
    parameter int INTERVAL = 256,
    parameter int CNT_W    = 16
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              en_i,
    input  logic              clr_cnt_i,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [71:0]       mem_wdata_o,
    input  logic              mem_gnt_i,
    input  logic              mem_rvalid_i,
    input  logic [71:0]       mem_rdata_i,
    output logic [71:0]       dec_in_o,
    input  logic [63:0]       dec_data_i,
    input  logic              dec_sec_i,
    input  logic              dec_ded_i,
    output logic [63:0]       enc_in_o,
    input  logic [71:0]       enc_out_i,
    output logic              err_valid_o,
    output logic              err_uncorr_o,
    output logic [ADDR_W-1:0] err_addr_o,
    output logic [CNT_W-1:0]  corr_cnt_o,
    output logic [CNT_W-1:0]  uncorr_cnt_o
);

    localparam int IW = (INTERVAL > 1) ? $clog2(INTERVAL) : 1;

    typedef enum logic [2:0] {
        IDLE,
        RD_REQ,
        RD_WAIT,
        CHECK,
        WR_REQ
    } state_e;

    state_e             state_q, state_d;
    logic [ADDR_W-1:0]  ptr_q, ptr_d;
    logic [IW-1:0]      icnt_q, icnt_d;
    logic [71:0]        dec_in_q, dec_in_d;
    logic [63:0]        enc_in_q, enc_in_d;
    logic               err_valid_q, err_valid_d;
    logic               err_uncorr_q, err_uncorr_d;
    logic [ADDR_W-1:0]  err_addr_q, err_addr_d;
    logic [CNT_W-1:0]   corr_q, corr_d;
    logic [CNT_W-1:0]   uncorr_q, uncorr_d;
    logic               corr_inc, uncorr_inc;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            ptr_q        <= '0;
            icnt_q       <= '0;
            dec_in_q     <= '0;
            enc_in_q     <= '0;
            err_valid_q  <= 1'b0;
            err_uncorr_q <= 1'b0;
            err_addr_q   <= '0;
            corr_q       <= '0;
            uncorr_q     <= '0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            icnt_q       <= icnt_d;
            dec_in_q     <= dec_in_d;
            enc_in_q     <= enc_in_d;
            err_valid_q  <= err_valid_d;
            err_uncorr_q <= err_uncorr_d;
            err_addr_q   <= err_addr_d;
            corr_q       <= corr_d;
            uncorr_q     <= uncorr_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        icnt_d       = icnt_q;
        dec_in_d     = dec_in_q;
        enc_in_d     = enc_in_q;
        err_valid_d  = 1'b0;
        err_uncorr_d = err_uncorr_q;
        err_addr_d   = err_addr_q;
        corr_inc     = 1'b0;
        uncorr_inc   = 1'b0;

        unique case (state_q)
            IDLE: begin
                // Counter holds while disabled, so re-enabling resumes the gap.
                if (en_i) begin
                    if (icnt_q == IW'(INTERVAL - 1)) begin
                        icnt_d  = '0;
                        state_d = RD_REQ;
                    end else begin
                        icnt_d = icnt_q + 1'b1;
                    end
                end
            end
            RD_REQ: begin
                if (mem_gnt_i) state_d = RD_WAIT;
            end
            RD_WAIT: begin
                if (mem_rvalid_i) begin
                    dec_in_d = mem_rdata_i;
                    state_d  = CHECK;
                end
            end
            CHECK: begin
                // DED wins: an uncorrectable word is never rewritten.
                if (dec_ded_i) begin
                    err_valid_d  = 1'b1;
                    err_uncorr_d = 1'b1;
                    err_addr_d   = ptr_q;
                    uncorr_inc   = 1'b1;
                    ptr_d        = ptr_q + 1'b1;
                    state_d      = IDLE;
                end else if (dec_sec_i) begin
                    enc_in_d     = dec_data_i;
                    err_valid_d  = 1'b1;
                    err_uncorr_d = 1'b0;
                    err_addr_d   = ptr_q;
                    corr_inc     = 1'b1;
                    state_d      = WR_REQ;
                end else begin
                    ptr_d   = ptr_q + 1'b1;
                    state_d = IDLE;
                end
            end
            WR_REQ: begin
                if (mem_gnt_i) begin
                    ptr_d   = ptr_q + 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        corr_d = corr_q;
        if (clr_cnt_i) corr_d = '0;
        else if (corr_inc && (corr_q != '1)) corr_d = corr_q + 1'b1;

        uncorr_d = uncorr_q;
        if (clr_cnt_i) uncorr_d = '0;
        else if (uncorr_inc && (uncorr_q != '1)) uncorr_d = uncorr_q + 1'b1;
    end

    assign mem_req_o    = (state_q == RD_REQ) || (state_q == WR_REQ);
    assign mem_we_o     = (state_q == WR_REQ);
    assign mem_addr_o   = mem_req_o ? ptr_q : '0;
    assign mem_wdata_o  = mem_we_o ? enc_out_i : '0;
    assign dec_in_o     = dec_in_q;
    assign enc_in_o     = enc_in_q;
    assign err_valid_o  = err_valid_q;
    assign err_uncorr_o = err_uncorr_q;
    assign err_addr_o   = err_addr_q;
    assign corr_cnt_o   = corr_q;
    assign uncorr_cnt_o = uncorr_q;

endmodule

// File: tb/tb_ecc_scrub_ctrl.sv
// tb_ecc_scrub_ctrl: directed bench for ecc_scrub_ctrl with a behavioural
// array, a Hsiao (72,64) encoder/decoder and an arbiter with stall controls.
module tb_ecc_scrub_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        clr_cnt = 1'b0;
    logic        mem_req_o, mem_we_o;
    logic [9:0]  mem_addr_o;
    logic [71:0] mem_wdata_o;
    logic        mem_gnt_i;
    logic        mem_rvalid_i;
    logic [71:0] mem_rdata_i;
    logic [71:0] dec_in_o;
    logic [63:0] dec_data_i;
    logic        dec_sec_i, dec_ded_i;
    logic [63:0] enc_in_o;
    logic [71:0] enc_out_i;
    logic        err_valid_o, err_uncorr_o;
    logic [9:0]  err_addr_o;
    logic [1:0]  corr_cnt_o, uncorr_cnt_o;

    always #5 clk = ~clk;

    ecc_scrub_ctrl #(.ADDR_W(10), .INTERVAL(4), .CNT_W(2)) dut (
        .clk_i(clk), .rst_ni(rst_n), .en_i(en), .clr_cnt_i(clr_cnt),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
        .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i),
        .mem_rdata_i(mem_rdata_i), .dec_in_o(dec_in_o),
        .dec_data_i(dec_data_i), .dec_sec_i(dec_sec_i),
        .dec_ded_i(dec_ded_i), .enc_in_o(enc_in_o), .enc_out_i(enc_out_i),
        .err_valid_o(err_valid_o), .err_uncorr_o(err_uncorr_o),
        .err_addr_o(err_addr_o), .corr_cnt_o(corr_cnt_o),
        .uncorr_cnt_o(uncorr_cnt_o)
    );

    // Hsiao columns: 56 weight-3 then 8 weight-5 check-bit patterns.
    logic [7:0] cols [64];

    function automatic logic [7:0] chk8(input logic [63:0] d);
        logic [7:0] c = '0;
        for (int i = 0; i < 64; i++) if (d[i]) c = c ^ cols[i];
        return c;
    endfunction

    function automatic logic [63:0] data_of(input int i);
        logic [31:0] a = 32'hC0DE0000 | 32'(i);
        logic [31:0] b = 32'h13579BDF ^ (32'(i) * 32'h9E3779B9);
        return {a, b};
    endfunction

    function automatic logic [71:0] golden(input int i);
        logic [63:0] d = data_of(i);
        return {chk8(d), d};
    endfunction

    logic [7:0] syn, ec;
    logic       hit;

    always_comb begin
        syn = dec_in_o[71:64];
        for (int i = 0; i < 64; i++) if (dec_in_o[i]) syn = syn ^ cols[i];
        dec_data_i = dec_in_o[63:0];
        dec_sec_i  = 1'b0;
        dec_ded_i  = 1'b0;
        hit        = 1'b0;
        for (int i = 0; i < 64; i++) begin
            if (cols[i] == syn) begin
                dec_data_i[i] = ~dec_in_o[i];
                hit = 1'b1;
            end
        end
        if ($countones(syn) == 1) hit = 1'b1;
        if (syn != 8'h00) begin
            if ((^syn) && hit) dec_sec_i = 1'b1;
            else dec_ded_i = 1'b1;
        end
    end

    always_comb begin
        ec = '0;
        for (int i = 0; i < 64; i++) if (enc_in_o[i]) ec = ec ^ cols[i];
        enc_out_i = {ec, enc_in_o};
    end

    // Array model and arbiter.
    logic [71:0] mem [1024];
    logic        block_rd = 1'b0, block_wr = 1'b0;
    logic        init_go = 1'b0, inj_go = 1'b0;
    logic [9:0]  inj_addr = '0;
    logic [71:0] inj_mask = '0;
    logic        rvalid;
    logic [71:0] rdata;
    logic [9:0]  rv_addr = '0, exp_rd, prev_rd = '0;
    int          rd_count = 0, wr_count = 0, ev_count = 0, seq_errs = 0;
    logic [9:0]  last_wr_addr = '0, ev_addr = '0;
    logic [71:0] last_wr_data = '0;
    logic        ev_uncorr = 1'b0, wrap_seen = 1'b0;

    assign mem_gnt_i = !(mem_req_o && ((block_rd && !mem_we_o) ||
                                       (block_wr && mem_we_o)));
    assign mem_rvalid_i = rvalid;
    assign mem_rdata_i  = rdata;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rvalid <= 1'b0;
            rdata  <= '0;
            exp_rd <= '0;
        end else begin
            if (init_go) for (int i = 0; i < 1024; i++) mem[i] <= golden(i);
            if (inj_go) mem[inj_addr] <= mem[inj_addr] ^ inj_mask;
            rvalid <= 1'b0;
            if (mem_req_o && mem_gnt_i) begin
                if (mem_we_o) begin
                    mem[mem_addr_o] <= mem_wdata_o;
                    wr_count     <= wr_count + 1;
                    last_wr_addr <= mem_addr_o;
                    last_wr_data <= mem_wdata_o;
                end else begin
                    rvalid   <= 1'b1;
                    rdata    <= mem[mem_addr_o];
                    rv_addr  <= mem_addr_o;
                    rd_count <= rd_count + 1;
                    if (mem_addr_o != exp_rd) seq_errs <= seq_errs + 1;
                    if (mem_addr_o == 10'd0 && prev_rd == 10'd1023) wrap_seen <= 1'b1;
                    prev_rd <= mem_addr_o;
                    exp_rd  <= mem_addr_o + 10'd1;
                end
            end
            if (err_valid_o) begin
                ev_count  <= ev_count + 1;
                ev_uncorr <= err_uncorr_o;
                ev_addr   <= err_addr_o;
            end
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [127:0] got,
                         input logic [127:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_for(input string tag, input int which,
                            input int target, input int bound);
        int n = 0;
        int cur = 0;
        while (n < bound) begin
            cur = (which == 0) ? rd_count : (which == 1) ? wr_count : ev_count;
            if (cur >= target) break;
            @(negedge clk);
            n++;
        end
        check(tag, 128'(n < bound), 128'(1));
    endtask

    task automatic inject(input logic [9:0] a, input logic [71:0] m);
        @(posedge clk);
        #1;
        inj_addr = a;
        inj_mask = m;
        inj_go   = 1'b1;
        @(posedge clk);
        #1;
        inj_go = 1'b0;
    endtask

    task automatic wait_req(input string tag, input logic we, input int bound);
        int n = 0;
        while (n < bound && !(mem_req_o && mem_we_o == we)) begin
            @(negedge clk);
            n++;
        end
        check(tag, 128'(n < bound), 128'(1));
    endtask

    initial begin
        int n;
        logic [9:0]  cap_addr, tgt, base;
        logic [71:0] m2;
        int          rc, wc;

        n = 0;
        for (int v = 0; v < 256; v++)
            if ($countones(v) == 3 && n < 64) begin cols[n] = 8'(v); n++; end
        for (int v = 0; v < 256; v++)
            if ($countones(v) == 5 && n < 64) begin cols[n] = 8'(v); n++; end

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_req", 128'(mem_req_o), 0);
        check("rst_bus", {mem_we_o, mem_addr_o, mem_wdata_o}, 0);
        check("rst_err", {err_valid_o, err_uncorr_o, err_addr_o}, 0);
        check("rst_cnt", {corr_cnt_o, uncorr_cnt_o}, 0);
        check("rst_dec_enc", {dec_in_o, enc_in_o}, 0);
        rst_n = 1'b1;
        @(posedge clk); #1 init_go = 1'b1;
        @(posedge clk); #1 init_go = 1'b0;
        en = 1'b1;

        // 1) clean sweep with wrap
        wait_for("sweep_reads", 0, 1026, 12000);
        check("sweep_no_wr", 128'(wr_count), 0);
        check("sweep_no_ev", 128'(ev_count), 0);
        check("sweep_cnt", {corr_cnt_o, uncorr_cnt_o}, 0);
        check("sweep_seq", 128'(seq_errs), 0);
        check("sweep_wrap", 128'(wrap_seen), 1);

        // 2) SEC at 0x12, bit 5
        inject(10'h012, 72'h20);
        wait_for("sec_wr", 1, 1, 2000);
        @(negedge clk);
        check("sec_wr_addr", 128'(last_wr_addr), 128'h12);
        check("sec_wr_data", 128'(last_wr_data), 128'(golden(32'h12)));
        check("sec_ev_count", 128'(ev_count), 1);
        check("sec_ev_uncorr", 128'(ev_uncorr), 0);
        check("sec_err_addr", 128'(err_addr_o), 128'h12);
        check("sec_corr_cnt", 128'(corr_cnt_o), 1);

        // 3) DED at 0x30, bits 3 and 40
        m2 = (72'd1 << 40) | 72'h8;
        inject(10'h030, m2);
        wait_for("ded_ev", 2, 2, 2000);
        repeat (3) @(negedge clk);
        check("ded_ev_uncorr", 128'(ev_uncorr), 1);
        check("ded_err_uncorr", 128'(err_uncorr_o), 1);
        check("ded_err_addr", 128'(err_addr_o), 128'h30);
        check("ded_uncorr_cnt", 128'(uncorr_cnt_o), 1);
        check("ded_no_wr", 128'(wr_count), 1);
        check("ded_corr_cnt", 128'(corr_cnt_o), 1);
        inject(10'h030, m2);

        // re-scrub whole array: both words now clean
        rc = rd_count;
        wait_for("rescrub", 0, rc + 1025, 12000);
        repeat (4) @(negedge clk);
        check("rescrub_no_wr", 128'(wr_count), 1);
        check("rescrub_no_ev", 128'(ev_count), 2);
        check("rescrub_word", 128'(mem[10'h012]), 128'(golden(32'h12)));

        // 4) read grant stall
        @(negedge clk);
        block_rd = 1'b1;
        wait_req("rd_stall_req", 1'b0, 100);
        cap_addr = mem_addr_o;
        check("rd_stall_addr", 128'(cap_addr), 128'(exp_rd));
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("rd_stall_hold", {mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o},
                  {1'b1, 1'b0, cap_addr, 72'h0});
        end
        block_rd = 1'b0;

        // write grant stall
        @(negedge clk);
        tgt = exp_rd + 10'd2;
        block_wr = 1'b1;
        wc = wr_count;
        inject(tgt, 72'd1 << 10);
        wait_req("wr_stall_req", 1'b1, 200);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("wr_stall_hold", {mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o},
                  {1'b1, 1'b1, tgt, golden(int'(tgt))});
        end
        block_wr = 1'b0;
        wait_for("wr_stall_done", 1, wc + 1, 50);
        check("wr_stall_word", 128'(mem[tgt]), 128'(golden(int'(tgt))));

        // 5) clear, then saturate CORR_CNT at 3
        @(posedge clk); #1 clr_cnt = 1'b1;
        @(posedge clk); #1 clr_cnt = 1'b0;
        check("clr_cnt", {corr_cnt_o, uncorr_cnt_o}, 0);
        base = exp_rd + 10'd3;
        wc = wr_count;
        for (int i = 0; i < 5; i++) inject(base + 10'(i), 72'd1 << (i + 1));
        wait_for("sat_wr", 1, wc + 5, 600);
        @(negedge clk);
        check("sat_corr", 128'(corr_cnt_o), 3);
        check("sat_uncorr", 128'(uncorr_cnt_o), 0);

        // CLR_CNT in the same cycle as a SEC increment
        tgt = exp_rd + 10'd3;
        inject(tgt, 72'h80);
        n = 0;
        while (n < 200 && !(mem_rvalid_i && rv_addr == tgt)) begin
            @(negedge clk);
            n++;
        end
        check("clr_race_rv", 128'(n < 200), 1);
        @(posedge clk); #1 clr_cnt = 1'b1;
        @(posedge clk); #1 clr_cnt = 1'b0;
        check("clr_race_cnt", 128'(corr_cnt_o), 0);
        check("clr_race_ev", {err_valid_o, err_uncorr_o, err_addr_o}, {2'b10, tgt});

        // 6) drop EN in RD_WAIT
        n = 0;
        while (n < 200 && !(mem_req_o && !mem_we_o && mem_gnt_i)) begin
            @(negedge clk);
            n++;
        end
        check("en_drop_req", 128'(n < 200), 1);
        rc = rd_count;
        tgt = mem_addr_o;
        @(posedge clk); #1 en = 1'b0;
        repeat (40) @(negedge clk);
        check("en_drop_reads", 128'(rd_count), 128'(rc + 1));
        check("en_drop_idle", 128'(mem_req_o), 0);
        check("en_drop_ptr", 128'(exp_rd), 128'(tgt + 10'd1));

        // reset while a write waits for grant
        en = 1'b1;
        block_wr = 1'b1;
        inject(exp_rd + 10'd1, 72'd1 << 20);
        wait_req("rst_wr_req", 1'b1, 200);
        rst_n = 1'b0;
        #1;
        check("rst_wr_bus", {mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o}, 0);
        check("rst_wr_err", {err_valid_o, err_uncorr_o, err_addr_o}, 0);
        check("rst_wr_cnt", {corr_cnt_o, uncorr_cnt_o}, 0);
        check("rst_wr_regs", {dec_in_o, enc_in_o}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        block_wr = 1'b0;
        wait_req("post_rst_req", 1'b0, 50);
        check("post_rst_addr", 128'(mem_addr_o), 0);
        repeat (10) @(negedge clk);
        check("final_seq", 128'(seq_errs), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
